// File: rtl/i2c_pkg.sv
// ============================================================================
// Module  : i2c_pkg
// Purpose : Shared types and constants for the I2C channel-select target.
// Revision: 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR       = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD       = 3'd5,
      ST_RD_ACK   = 3'd6
   } i2c_state_t;

   localparam logic [3:0] SEL_NONE = 4'd0;
   localparam logic [3:0] SEL_MAX  = 4'd8;
   localparam logic       I2C_ACK  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
// Module  : i2c_sync_edge
// Purpose : Two-flop synchronizer plus history flop with edge outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_hist;

   // Idle I2C lines sit high, so resetting high avoids a phantom edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_hist <= 1'b1;
      end else begin
         r_meta <= pin_in;
         r_sync <= r_meta;
         r_hist <= r_sync;
      end
   end

   assign level = r_sync;
   assign rise  = r_sync & ~r_hist;
   assign fall  = ~r_sync & r_hist;

endmodule

`default_nettype wire

// File: rtl/i2c_mux_ctrl.sv
// ============================================================================
// Module  : i2c_mux_ctrl
// Purpose : I2C target holding the 4-bit channel select of a bus demux.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_mux_ctrl
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR = 7'h70
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [3:0] select,
   output logic       select_upd,
   output logic       busy
);

   logic w_scl_level, w_scl_rise, w_scl_fall;
   logic w_sda_level, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;

   i2c_state_t r_state, w_state_nx;
   logic [3:0] r_cnt, w_cnt_nx;
   logic [7:0] r_shift, w_shift_nx;
   logic       r_rw, w_rw_nx;
   logic       r_oe, w_oe_nx;
   logic [3:0] r_sel, w_sel_nx;
   logic       r_upd, w_upd_nx;
   logic       r_busy, w_busy_nx;
   logic [7:0] w_rd_load;
   logic [2:0] w_bit_idx;

   i2c_sync_edge u_scl (
      .clk    (clk),
      .reset  (reset),
      .pin_in (scl_in),
      .level  (w_scl_level),
      .rise   (w_scl_rise),
      .fall   (w_scl_fall)
   );

   i2c_sync_edge u_sda (
      .clk    (clk),
      .reset  (reset),
      .pin_in (sda_in),
      .level  (w_sda_level),
      .rise   (w_sda_rise),
      .fall   (w_sda_fall)
   );

   assign w_start   = w_sda_fall & w_scl_level;
   assign w_stop    = w_sda_rise & w_scl_level;
   assign w_rd_load = {4'b0000, r_sel};
   assign w_bit_idx = 3'd7 - r_cnt[2:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_shift <= 8'd0;
         r_rw    <= 1'b0;
         r_oe    <= 1'b0;
         r_sel   <= SEL_NONE;
         r_upd   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_shift <= w_shift_nx;
         r_rw    <= w_rw_nx;
         r_oe    <= w_oe_nx;
         r_sel   <= w_sel_nx;
         r_upd   <= w_upd_nx;
         r_busy  <= w_busy_nx;
      end
   end

   // Byte decisions are taken on the SCL fall after the 8th bit so that
   // the ACK drive always begins on a falling edge.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_shift_nx = r_shift;
      w_rw_nx    = r_rw;
      w_oe_nx    = r_oe;
      w_sel_nx   = r_sel;
      w_upd_nx   = 1'b0;
      w_busy_nx  = r_busy;

      if (w_stop) begin
         w_state_nx = ST_IDLE;
         w_cnt_nx   = 4'd0;
         w_oe_nx    = 1'b0;
         w_busy_nx  = 1'b0;
      end else if (w_start) begin
         w_state_nx = ST_ADDR;
         w_cnt_nx   = 4'd0;
         w_oe_nx    = 1'b0;
         w_busy_nx  = 1'b1;
      end else begin
         case (r_state)
            ST_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nx = {r_shift[6:0], w_sda_level};
                  w_cnt_nx   = r_cnt + 4'd1;
               end else if (w_scl_fall && (r_cnt == 4'd8)) begin
                  if (r_shift[7:1] == ADDR) begin
                     w_state_nx = ST_ADDR_ACK;
                     w_rw_nx    = r_shift[0];
                     w_oe_nx    = 1'b1;
                  end else begin
                     w_state_nx = ST_IDLE;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_cnt_nx = 4'd0;
                  if (r_rw) begin
                     w_state_nx = ST_RD;
                     w_shift_nx = w_rd_load;
                     w_oe_nx    = ~w_rd_load[7];
                  end else begin
                     w_state_nx = ST_WR;
                     w_oe_nx    = 1'b0;
                  end
               end
            end
            ST_WR: begin
               if (w_scl_rise) begin
                  w_shift_nx = {r_shift[6:0], w_sda_level};
                  w_cnt_nx   = r_cnt + 4'd1;
               end else if (w_scl_fall && (r_cnt == 4'd8)) begin
                  w_state_nx = ST_WR_ACK;
                  if (r_shift <= {4'b0000, SEL_MAX}) begin
                     w_oe_nx  = 1'b1;
                     w_sel_nx = r_shift[3:0];
                     w_upd_nx = 1'b1;
                  end
               end
            end
            ST_WR_ACK: begin
               if (w_scl_fall) begin
                  w_state_nx = ST_WR;
                  w_cnt_nx   = 4'd0;
                  w_oe_nx    = 1'b0;
               end
            end
            ST_RD: begin
               if (w_scl_rise) begin
                  w_cnt_nx = r_cnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_state_nx = ST_RD_ACK;
                     w_oe_nx    = 1'b0;
                  end else begin
                     w_oe_nx = ~r_shift[w_bit_idx];
                  end
               end
            end
            ST_RD_ACK: begin
               // The next data byte starts driving on the following SCL fall.
               if (w_scl_rise) begin
                  w_cnt_nx = 4'd0;
                  if (w_sda_level == I2C_ACK) begin
                     w_state_nx = ST_RD;
                  end else begin
                     w_state_nx = ST_IDLE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sda_oe     = r_oe;
   assign select     = r_sel;
   assign select_upd = r_upd;
   assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_mux_ctrl.sv
// ============================================================================
// Module  : tb_i2c_mux_ctrl
// Purpose : Bus-level I2C controller model and self-checking bench.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2c_mux_ctrl;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic [3:0] select;
   logic       select_upd;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         upd_cnt = 0;
   int         exp_upd = 0;
   logic [3:0] sel_model = 4'd0;
   logic [3:0] exp_upd_val = 4'd0;
   logic       nd_frame = 1'b0;
   logic       nd_byte = 1'b0;
   logic       frame_ok = 1'b0;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_mux_ctrl #(.ADDR(7'h70)) dut (
      .clk        (clk),
      .reset      (reset),
      .scl_in     (scl_m),
      .sda_in     (sda_bus),
      .sda_oe     (sda_oe),
      .select     (select),
      .select_upd (select_upd),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic waitq(input int n = Q);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer_bit(input logic b, input logic arm, output logic smp);
      waitq();
      sda_m = b;
      if (arm) nd_byte = 1'b1;
      waitq();
      scl_m = 1'b1;
      waitq();
      smp = sda_bus;
      waitq();
      scl_m = 1'b0;
   endtask

   task automatic do_start();
      if (!scl_m) begin
         waitq();
         sda_m = 1'b1;
         waitq();
         scl_m = 1'b1;
         waitq();
      end
      sda_m = 1'b0;
      waitq();
      scl_m = 1'b0;
      waitq(2);
      chk("busy_after_start", busy, 1);
   endtask

   task automatic do_stop();
      waitq();
      sda_m = 1'b0;
      waitq();
      scl_m = 1'b1;
      waitq();
      sda_m = 1'b1;
      waitq(2 * Q);
      chk("busy_after_stop", busy, 0);
      chk("oe_after_stop", sda_oe, 0);
      chk("select_after_stop", select, sel_model);
   endtask

   task automatic write_byte(input logic [7:0] b, input logic is_addr, output logic ack);
      logic s;
      logic exp_ack;
      logic reject;
      if (is_addr) begin
         frame_ok = (b[7:1] == 7'h70);
         exp_ack  = frame_ok;
      end else begin
         exp_ack = frame_ok && (b <= 8'd8);
      end
      reject = !is_addr && !exp_ack;
      exp_upd_val = b[3:0];
      for (int i = 7; i >= 0; i--) xfer_bit(b[i], reject && (i == 7), s);
      xfer_bit(1'b1, 1'b0, s);
      ack = ~s;
      nd_byte = 1'b0;
      if (!is_addr && exp_ack) begin
         sel_model = b[3:0];
         exp_upd++;
      end
      chk(is_addr ? "addr_ack" : "data_ack", ack, exp_ack);
      chk("upd_count", upd_cnt, exp_upd);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b1, 1'b0, s);
         d[i] = s;
      end
      xfer_bit(~mack, 1'b0, s);
      chk("read_data", d, {4'b0000, sel_model});
   endtask

   task automatic write_frame(input logic [7:0] b);
      logic a;
      do_start();
      write_byte(8'hE0, 1'b1, a);
      write_byte(b, 1'b0, a);
      do_stop();
   endtask

   // Per-cycle invariants checked against the bench-side expectations.
   logic       p_scl = 1'b1;
   logic       p_oe = 1'b0;
   logic       p_upd = 1'b0;
   logic       p_rst = 1'b1;
   logic [3:0] p_sel = 4'd0;

   always @(posedge clk) begin
      #1;
      if (!reset && !p_rst) begin
         if (p_scl && scl_m) chk("oe_stable_scl_high", sda_oe, p_oe);
         if (nd_frame || nd_byte) chk("oe_forbidden", sda_oe, 0);
         if (select_upd) begin
            upd_cnt++;
            chk("upd_value", select, exp_upd_val);
            chk("upd_single", p_upd, 0);
         end else begin
            chk("sel_hold", select, p_sel);
         end
      end
      p_scl = scl_m;
      p_oe  = sda_oe;
      p_upd = select_upd;
      p_rst = reset;
      p_sel = select;
   end

   initial begin
      logic       a;
      logic [7:0] d;
      logic       s;
      int         kind;
      int         n;
      logic [6:0] ad;

      repeat (3) @(negedge clk);
      chk("rst_oe", sda_oe, 0);
      chk("rst_select", select, 0);
      chk("rst_upd", select_upd, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      waitq();

      // Write 0x03.
      do_start();
      write_byte(8'hE0, 1'b1, a);
      chk("lit_addr_ack", a, 1);
      write_byte(8'h03, 1'b0, a);
      chk("lit_data_ack", a, 1);
      do_stop();
      chk("lit_select3", select, 3);
      chk("lit_upd1", upd_cnt, 1);

      // Out-of-range byte is rejected.
      write_frame(8'h09);
      chk("lit_select_kept", select, 3);
      chk("lit_upd_still1", upd_cnt, 1);

      // Foreign address.
      nd_frame = 1'b1;
      do_start();
      write_byte(8'hE2, 1'b1, a);
      chk("lit_foreign_nack", a, 0);
      write_byte(8'h01, 1'b0, a);
      do_stop();
      nd_frame = 1'b0;
      chk("lit_foreign_sel", select, 3);

      // Select 5 then read twice.
      write_frame(8'h05);
      do_start();
      write_byte(8'hE1, 1'b1, a);
      read_byte(1'b1, d);
      chk("lit_read0", d, 8'h05);
      read_byte(1'b0, d);
      chk("lit_read1", d, 8'h05);
      do_stop();

      // Write 2, repeated START, read back.
      do_start();
      write_byte(8'hE0, 1'b1, a);
      write_byte(8'h02, 1'b0, a);
      do_start();
      write_byte(8'hE1, 1'b1, a);
      read_byte(1'b0, d);
      chk("lit_sr_read", d, 8'h02);
      do_stop();

      // Reset while the data ACK is being driven.
      do_start();
      write_byte(8'hE0, 1'b1, a);
      exp_upd_val = 4'd4;
      for (int i = 7; i >= 0; i--) xfer_bit(i == 2, 1'b0, s);
      exp_upd++;
      waitq();
      chk("ack_driven", sda_oe, 1);
      chk("ack_select4", select, 4);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_oe", sda_oe, 0);
      chk("async_rst_sel", select, 0);
      sel_model = 4'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      waitq();
      scl_m = 1'b1;
      waitq(2 * Q);
      scl_m = 1'b0;
      do_stop();
      chk("upd_after_rst", upd_cnt, exp_upd);
      write_frame(8'h06);
      chk("lit_select6", select, 6);

      // Randomized traffic.
      for (int t = 0; t < 25; t++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: begin
               do_start();
               write_byte(8'hE0, 1'b1, a);
               n = $urandom_range(1, 3);
               for (int k = 0; k < n; k++) write_byte(8'($urandom_range(0, 15)), 1'b0, a);
               do_stop();
            end
            1: begin
               do_start();
               write_byte(8'hE1, 1'b1, a);
               n = $urandom_range(1, 3);
               for (int k = 0; k < n; k++) read_byte(k != n - 1, d);
               do_stop();
            end
            2: begin
               ad = 7'($urandom_range(0, 127));
               if (ad == 7'h70) ad = 7'h71;
               nd_frame = 1'b1;
               do_start();
               write_byte({ad, 1'($urandom_range(0, 1))}, 1'b1, a);
               write_byte(8'($urandom_range(0, 15)), 1'b0, a);
               do_stop();
               nd_frame = 1'b0;
            end
            3: begin
               do_start();
               write_byte(8'hE0, 1'b1, a);
               write_byte(8'($urandom_range(0, 15)), 1'b0, a);
               do_start();
               write_byte(8'hE1, 1'b1, a);
               read_byte(1'b0, d);
               do_stop();
            end
            default: begin
               do_start();
               write_byte(8'hE0, 1'b1, a);
               d = 8'($urandom_range(0, 8));
               n = $urandom_range(1, 7);
               for (int k = 0; k < n; k++) xfer_bit(d[7 - k], 1'b0, s);
               do_stop();
               chk("abort_upd", upd_cnt, exp_upd);
            end
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
